// File: rtl/updi_phy_pkg.sv
// updi_phy_pkg: FSM state types, 8E2 frame constants and the parity helper for updi_phy.
package updi_phy_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 2;

    typedef enum logic [2:0] {
        TX_IDLE, TX_LOAD, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
    } tx_state_e;

    typedef enum logic [2:0] {
        BRK_IDLE, BRK_LOW1, BRK_HIGH1, BRK_LOW2, BRK_HIGH2, BRK_DONE
    } brk_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP1, RX_STOP2
    } rx_state_e;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/updi_fifo.sv
// updi_fifo: synchronous show-ahead FIFO with full/almost_full/empty/almost_empty flags.
module updi_fifo #(
    parameter int DEPTH = 16,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] wr_data,
    input  logic         wr_en,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         almost_full,
    output logic         empty,
    output logic         almost_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0] cnt_q, cnt_d;
    logic wr_ok, rd_ok;

    assign full = cnt_q == DEPTH_C;
    assign almost_full = cnt_q >= DEPTH_C - 1'b1;
    assign empty = cnt_q == '0;
    assign almost_empty = cnt_q <= (AW+1)'(1);
    assign rd_data = empty ? '0 : mem_q[rptr_q];

    always_comb begin
        wr_ok = wr_en && !full;
        rd_ok = rd_en && !empty;
        wptr_d = wptr_q + AW'(wr_ok);
        rptr_d = rptr_q + AW'(rd_ok);
        cnt_d = cnt_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wptr_q] <= wr_data;
    end

endmodule

// File: rtl/updi_phy.sv
// updi_phy: open-drain 8E2 UPDI line PHY with TX/RX FIFOs and double-break generator.
// Define UPDI_PHY_RX_ECHO_EN to keep the receiver listening while transmitting.
module updi_phy
    import updi_phy_pkg::*;
#(
    parameter int DOUBLE_BREAK_PULSE_CLK = 300000,
    parameter int UART_CLKS_PER_BIT = 100,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] uart_tx_fifo_data,
    input  logic       uart_tx_fifo_wr_en,
    output logic       uart_tx_fifo_full,
    output logic       uart_tx_fifo_almost_full,
    output logic [7:0] uart_rx_fifo_data,
    input  logic       uart_rx_fifo_rd_en,
    output logic       uart_rx_fifo_empty,
    output logic       uart_rx_fifo_almost_empty,
    output logic       rx_error,
    input  logic       double_break_start,
    output logic       double_break_busy,
    output logic       double_break_done,
    inout  wire        updi
);
    localparam int CW = $clog2(UART_CLKS_PER_BIT);
    localparam int BW = $clog2(DOUBLE_BREAK_PULSE_CLK);
    localparam logic [CW-1:0] BIT_END = CW'(UART_CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(UART_CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BRK_END = BW'(DOUBLE_BREAK_PULSE_CLK - 1);

    brk_state_e brk_q, brk_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic brk_start;

    tx_state_e tx_q, tx_d;
    logic [CW-1:0] tcnt_q, tcnt_d;
    logic [DATA_BITS-1:0] tsh_q, tsh_d, tx_head;
    logic [2:0] tbit_q, tbit_d;
    logic tpar_q, tpar_d, tx_bit_end, tx_fifo_rd, tx_fifo_empty, tx_low, uart_tx_active;

    rx_state_e rx_q, rx_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic [DATA_BITS-1:0] rsh_q, rsh_d;
    logic [2:0] rbit_q, rbit_d;
    logic s1_q, s2_q, prev_q, rx_err_q, rx_err_d, rx_tick, rx_en, rx_fifo_wr, rx_fifo_full;
    logic tx_fifo_unused_ae, rx_fifo_unused_af;

    assign brk_start = double_break_start && !double_break_busy;
    assign double_break_busy = brk_q inside {BRK_LOW1, BRK_HIGH1, BRK_LOW2, BRK_HIGH2};
    assign double_break_done = brk_q == BRK_DONE;
    assign uart_tx_active = tx_q != TX_IDLE;
    assign rx_error = rx_err_q;
    assign tx_low = (tx_q inside {TX_LOAD, TX_START}) || (tx_q == TX_DATA && !tsh_q[0])
                 || (tx_q == TX_PARITY && !tpar_q);
    assign updi = (tx_low || brk_q inside {BRK_LOW1, BRK_LOW2}) ? 1'b0 : 1'bz;

`ifdef UPDI_PHY_RX_ECHO_EN
    assign rx_en = !double_break_busy;
`else
    assign rx_en = !double_break_busy && !uart_tx_active;
`endif

    always_comb begin
        brk_d = brk_q;
        bcnt_d = bcnt_q + 1'b1;
        if (brk_q == BRK_IDLE || brk_q == BRK_DONE) begin
            brk_d = brk_start ? BRK_LOW1 : BRK_IDLE;
            bcnt_d = '0;
        end else if (bcnt_q == BRK_END) begin
            brk_d = brk_state_e'(brk_q + 3'd1);
            bcnt_d = '0;
        end
    end

    // LOAD is the first clock of the start bit, so START counts from 1.
    always_comb begin
        tx_d = tx_q;
        tsh_d = tsh_q;
        tpar_d = tpar_q;
        tbit_d = tbit_q;
        tx_fifo_rd = 1'b0;
        tx_bit_end = tcnt_q == BIT_END;
        tcnt_d = tx_bit_end ? '0 : tcnt_q + 1'b1;
        case (tx_q)
            TX_IDLE:   tcnt_d = '0;
            TX_LOAD:   tx_d = TX_START;
            TX_START:  if (tx_bit_end) begin tx_d = TX_DATA; tbit_d = '0; end
            TX_DATA:   if (tx_bit_end) begin
                           tsh_d = tsh_q >> 1;
                           tbit_d = tbit_q + 3'd1;
                           tx_d = (tbit_q == 3'(DATA_BITS - 1)) ? TX_PARITY : TX_DATA;
                       end
            TX_PARITY: if (tx_bit_end) tx_d = TX_STOP1;
            TX_STOP1:  if (tx_bit_end) tx_d = TX_STOP2;
            TX_STOP2:  if (tx_bit_end) tx_d = TX_IDLE;
            default:   tx_d = TX_IDLE;
        endcase
        if (tx_d == TX_IDLE && !tx_fifo_empty && !double_break_busy && !brk_start) begin
            tx_fifo_rd = 1'b1;
            tsh_d = tx_head;
            tpar_d = even_parity(tx_head);
            tcnt_d = '0;
            tx_d = TX_LOAD;
        end
        if (double_break_busy || brk_start) tx_d = TX_IDLE;
    end

    always_comb begin
        rx_d = rx_q;
        rsh_d = rsh_q;
        rbit_d = rbit_q;
        rx_err_d = 1'b0;
        rx_fifo_wr = 1'b0;
        rx_tick = rcnt_q == ((rx_q == RX_START) ? HALF_END : BIT_END);
        rcnt_d = rx_tick ? '0 : rcnt_q + 1'b1;
        case (rx_q)
            RX_IDLE:   begin rcnt_d = '0; rx_d = (prev_q && !s2_q) ? RX_START : RX_IDLE; end
            RX_START:  if (rx_tick) begin rx_d = s2_q ? RX_IDLE : RX_DATA; rbit_d = '0; end
            RX_DATA:   if (rx_tick) begin
                           rsh_d = {s2_q, rsh_q[DATA_BITS-1:1]};
                           rbit_d = rbit_q + 3'd1;
                           rx_d = (rbit_q == 3'(DATA_BITS - 1)) ? RX_PARITY : RX_DATA;
                       end
            RX_PARITY: if (rx_tick) begin
                           rx_err_d = s2_q != even_parity(rsh_q);
                           rx_d = rx_err_d ? RX_IDLE : RX_STOP1;
                       end
            RX_STOP1:  if (rx_tick) begin rx_err_d = !s2_q; rx_d = s2_q ? RX_STOP2 : RX_IDLE; end
            RX_STOP2:  if (rx_tick) begin
                           rx_err_d = !s2_q || rx_fifo_full;
                           rx_fifo_wr = !rx_err_d;
                           rx_d = RX_IDLE;
                       end
            default:   rx_d = RX_IDLE;
        endcase
        if (!rx_en) begin
            rx_d = RX_IDLE;
            rx_err_d = 1'b0;
            rx_fifo_wr = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            brk_q <= BRK_IDLE;
            bcnt_q <= '0;
            tx_q <= TX_IDLE;
            tcnt_q <= '0;
            tsh_q <= '0;
            tpar_q <= 1'b0;
            tbit_q <= '0;
            rx_q <= RX_IDLE;
            rcnt_q <= '0;
            rsh_q <= '0;
            rbit_q <= '0;
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            prev_q <= 1'b1;
            rx_err_q <= 1'b0;
        end else begin
            brk_q <= brk_d;
            bcnt_q <= bcnt_d;
            tx_q <= tx_d;
            tcnt_q <= tcnt_d;
            tsh_q <= tsh_d;
            tpar_q <= tpar_d;
            tbit_q <= tbit_d;
            rx_q <= rx_d;
            rcnt_q <= rcnt_d;
            rsh_q <= rsh_d;
            rbit_q <= rbit_d;
            s1_q <= updi;
            s2_q <= s1_q;
            prev_q <= s2_q;
            rx_err_q <= rx_err_d;
        end
    end

    updi_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_BITS)) u_tx_fifo (
        .clk(clk), .rst(rst),
        .wr_data(uart_tx_fifo_data), .wr_en(uart_tx_fifo_wr_en),
        .rd_en(tx_fifo_rd), .rd_data(tx_head),
        .full(uart_tx_fifo_full), .almost_full(uart_tx_fifo_almost_full),
        .empty(tx_fifo_empty), .almost_empty(tx_fifo_unused_ae)
    );

    updi_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_BITS)) u_rx_fifo (
        .clk(clk), .rst(rst),
        .wr_data(rsh_q), .wr_en(rx_fifo_wr),
        .rd_en(uart_rx_fifo_rd_en), .rd_data(uart_rx_fifo_data),
        .full(rx_fifo_full), .almost_full(rx_fifo_unused_af),
        .empty(uart_rx_fifo_empty), .almost_empty(uart_rx_fifo_almost_empty)
    );

endmodule

// File: tb/tb_updi_phy.sv
// tb_updi_phy: directed self-checking bench for updi_phy (breaks, TX frames, RX framing errors, FIFO limits).
module tb_updi_phy;
    localparam int P = 250;
    localparam int CPB = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic tx_wr = 1'b0, rx_rd = 1'b0, brk_start = 1'b0, drv_low = 1'b0;
    logic tx_full, tx_af, rx_empty, rx_ae, rx_err, busy, done;
    logic [7:0] rx_data;
    logic [7:0] pat [DEPTH+1] = '{8'h3C, 8'h81, 8'h00, 8'hE7, 8'h5A};
    wire updi;
    int checks = 0, errors = 0, edges = 0;

    pullup (updi);
    assign updi = drv_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;
    always @(posedge clk) edges++;

    updi_phy #(.DOUBLE_BREAK_PULSE_CLK(P), .UART_CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .uart_tx_fifo_data(tx_data), .uart_tx_fifo_wr_en(tx_wr),
        .uart_tx_fifo_full(tx_full), .uart_tx_fifo_almost_full(tx_af),
        .uart_rx_fifo_data(rx_data), .uart_rx_fifo_rd_en(rx_rd),
        .uart_rx_fifo_empty(rx_empty), .uart_rx_fifo_almost_empty(rx_ae),
        .rx_error(rx_err),
        .double_break_start(brk_start), .double_break_busy(busy), .double_break_done(done),
        .updi(updi)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Samples one full 8E2 frame starting at the current negedge; ends on the negedge after it.
    task automatic frame_bad(input logic [7:0] b, inout int bad);
        logic [11:0] f;
        f = {2'b11, ^b, b, 1'b0};
        for (int k = 0; k < 12*CPB; k++) begin
            if (updi !== f[k/CPB] || dut.uart_tx_active !== 1'b1) bad++;
            @(negedge clk);
        end
    endtask

    task automatic send_rx(input logic [11:0] f, output int errs);
        errs = 0;
        for (int k = 0; k < 14*CPB; k++) begin
            drv_low = (k < 12*CPB) ? !f[k/CPB] : 1'b0;
            @(negedge clk);
            if (rx_err) errs++;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 5*P) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int bad, errs, e0, n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rx_empty", rx_empty, 1);
        check("rst_rx_ae", rx_ae, 1);
        check("rst_rx_data", rx_data, 0);
        check("rst_tx_full", tx_full, 0);
        check("rst_tx_af", tx_af, 0);
        check("rst_rx_err", rx_err, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_line", updi, 1);
        check("rst_tx_active", dut.uart_tx_active, 0);

        brk_start = 1'b1;
        @(negedge clk);
        brk_start = 1'b0;
        e0 = edges;
        bad = 0;
        for (int k = 1; k <= 4*P; k++) begin
            if ((updi === 1'b0) != ((k <= P) || (k > 2*P && k <= 3*P)) || !busy || done) bad++;
            @(negedge clk);
        end
        check("brk_shape", bad, 0);
        check("brk_done", done, 1);
        check("brk_done_edges", edges - e0, 4*P);
        check("brk_busy_end", busy, 0);
        @(negedge clk);
        check("brk_done_pulse", done, 0);

        tx_data = 8'h55;
        tx_wr = 1'b1;
        @(negedge clk);
        tx_wr = 1'b0;
        check("tx_active_w", dut.uart_tx_active, 0);
        @(negedge clk);
        check("tx_active_w1", dut.uart_tx_active, 1);
        bad = 0;
        frame_bad(8'h55, bad);
        check("tx_frame_55", bad, 0);
        check("tx_active_after", dut.uart_tx_active, 0);
        check("tx_line_after", updi, 1);

        send_rx({2'b11, 1'b0, 8'hA3, 1'b0}, errs);
        check("rx_a3_err", errs, 0);
        check("rx_a3_empty", rx_empty, 0);
        check("rx_a3_data", rx_data, 8'hA3);
        check("rx_a3_ae", rx_ae, 1);
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
        check("rx_pop_empty", rx_empty, 1);

        send_rx({2'b11, 1'b1, 8'hA3, 1'b0}, errs);
        check("rx_par_err", errs, 1);
        check("rx_par_empty", rx_empty, 1);
        send_rx({1'b1, 1'b0, 1'b1, 8'h01, 1'b0}, errs);
        check("rx_stop_err", errs, 1);
        check("rx_stop_empty", rx_empty, 1);

        drv_low = 1'b1;
        repeat (2) @(negedge clk);
        drv_low = 1'b0;
        errs = 0;
        repeat (3*CPB) begin
            @(negedge clk);
            if (rx_err) errs++;
        end
        check("rx_glitch_err", errs, 0);
        check("rx_glitch_empty", rx_empty, 1);

        send_rx({2'b11, 1'b1, 8'h01, 1'b0}, errs);
        check("rx_01_err", errs, 0);
        send_rx({2'b11, 1'b0, 8'hFF, 1'b0}, errs);
        check("rx_ff_err", errs, 0);
        check("rx_two_ae", rx_ae, 0);
        check("rx_head_01", rx_data, 8'h01);
        rx_rd = 1'b1;
        @(negedge clk);
        check("rx_head_ff", rx_data, 8'hFF);
        @(negedge clk);
        rx_rd = 1'b0;
        check("rx_drained", rx_empty, 1);

        brk_start = 1'b1;
        @(negedge clk);
        brk_start = 1'b0;
        e0 = edges;
        for (int i = 0; i < DEPTH + 1; i++) begin
            tx_data = pat[i];
            tx_wr = 1'b1;
            @(negedge clk);
            if (i == DEPTH - 2) begin
                check("fifo_af", tx_af, 1);
                check("fifo_not_full", tx_full, 0);
            end
        end
        tx_wr = 1'b0;
        check("fifo_full", tx_full, 1);
        check("fifo_no_tx_in_brk", dut.uart_tx_active, 0);
        brk_start = 1'b1;
        @(negedge clk);
        brk_start = 1'b0;
        wait_done(n);
        check("brk2_done_edges", edges - e0, 4*P);
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) frame_bad(pat[i], bad);
        check("fifo_frames", bad, 0);
        check("fifo_full_after", tx_full, 0);
        n = 0;
        repeat (3*CPB) begin
            if (dut.uart_tx_active) n++;
            @(negedge clk);
        end
        check("fifo_no_extra", n, 0);

        tx_data = 8'hFF;
        tx_wr = 1'b1;
        @(negedge clk);
        tx_wr = 1'b0;
        repeat (4*CPB) @(negedge clk);
        check("abort_pre_active", dut.uart_tx_active, 1);
        check("abort_pre_line", updi, 1);
        brk_start = 1'b1;
        @(negedge clk);
        brk_start = 1'b0;
        e0 = edges;
        check("abort_line_low", updi, 0);
        check("abort_tx_idle", dut.uart_tx_active, 0);
        check("abort_busy", busy, 1);
        wait_done(n);
        check("abort_done_edges", edges - e0, 4*P);
        n = 0;
        repeat (3*CPB) begin
            @(negedge clk);
            if (dut.uart_tx_active) n++;
        end
        check("abort_byte_lost", n, 0);

        tx_data = 8'h00;
        tx_wr = 1'b1;
        @(negedge clk);
        tx_wr = 1'b0;
        repeat (2*CPB) @(negedge clk);
        check("rst_mid_line_low", updi, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_line", updi, 1);
        check("rst_mid_active", dut.uart_tx_active, 0);
        repeat (2*CPB) @(negedge clk);
        check("rst_mid_no_frame", dut.uart_tx_active, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
